// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM access arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int OWNER_W = 1;
   localparam int CNT_W   = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter. RAM_ARB_ROUND_ROBIN_EN selects round-robin on ties;
// otherwise requester 0 has fixed priority.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic               valid0_i,
   input  logic               valid1_i,
   input  logic [OWNER_W-1:0] last_i,
   output logic               grant0_o,
   output logic               grant1_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // On a tie the requester that was not granted last wins.
   assign grant0_o = valid0_i & (~valid1_i | last_i[0]);
   assign grant1_o = valid1_i & (~valid0_i | ~last_i[0]);
`else
   logic unused_last;
   assign unused_last = last_i[0];
   assign grant0_o    = valid0_i;
   assign grant1_o    = valid1_i & ~valid0_i;
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port clocked RAM between two valid/ready requesters.
// Arbitration mode is chosen by RAM_ARB_ROUND_ROBIN_EN (see rr_arb2).
//
// state  | meaning
// IDLE   | RAM pins quiet, grant offered to the arbitrated requester
// ACCESS | one cycle driving addr/wdata/r_w to the RAM
// WAIT   | read in flight, RD_LAT-1 cycles counted down
// RESP   | read data sampled (reads) / write completion pulse visible
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 1,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_r_w,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [OWNER_W-1:0]  owner_q, owner_d;
   logic [OWNER_W-1:0]  last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp0_valid_q, rsp0_valid_d;
   logic                rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
   logic                grant0, grant1;
   logic                done;
   logic [DATA_W-1:0]   done_data;

   rr_arb2 u_arb (
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .last_i   (last_q),
      .grant0_o (grant0),
      .grant1_o (grant1)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      done      = 1'b0;
      done_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant0 | grant1) begin
               owner_d = OWNER_W'(grant1);
               last_d  = OWNER_W'(grant1);
               we_d    = grant1 ? req1_we    : req0_we;
               addr_d  = grant1 ? req1_addr  : req0_addr;
               wdata_d = grant1 ? req1_wdata : req0_wdata;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Write completion is registered here so the pulse lands in RESP.
            if (we_q) begin
               state_d = ST_RESP;
               done    = 1'b1;
            end else if (RD_LAT == 1) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(RD_LAT - 1);
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!we_q) begin
               done      = 1'b1;
               done_data = ram_rdata;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rsp0_valid_d = done & (owner_q == OWNER_W'(0));
      rsp1_valid_d = done & (owner_q == OWNER_W'(1));
      rsp0_rdata_d = rsp0_valid_d ? done_data : rsp0_rdata_q;
      rsp1_rdata_d = rsp1_valid_d ? done_data : rsp1_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_q       <= OWNER_W'(1);
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   assign req0_ready = (state_q == ST_IDLE) & grant0;
   assign req1_ready = (state_q == ST_IDLE) & grant1;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp1_rdata = rsp1_rdata_q;
   assign busy       = (state_q != ST_IDLE);
   assign ram_r_w    = (state_q == ST_ACCESS) & we_q;
   assign ram_addr   = (state_q == ST_IDLE)   ? '0 : addr_q;
   assign ram_wdata  = (state_q == ST_ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: main instance at RD_LAT=1, second at RD_LAT=3.
module tb_ram_access_arbiter;

   localparam int DW = 8;
   localparam int AW = 1;
   localparam int RD_LAT = 1;

   typedef struct {
      int         port;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic clear;
   logic req0_valid, req0_we, req0_ready, rsp0_valid;
   logic req1_valid, req1_we, req1_ready, rsp1_valid;
   logic [AW-1:0] req0_addr, req1_addr, ram_addr;
   logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, ram_wdata, ram_rdata;
   logic ram_r_w, busy;

   logic b_clear, b_valid, b_we, b_ready, b_rsp_valid, b_ram_r_w, b_busy;
   logic b1_ready, b1_rsp_valid;
   logic [AW-1:0] b_addr, b_ram_addr;
   logic [DW-1:0] b_wdata, b_rsp_rdata, b1_rsp_rdata, b_ram_wdata, b_ram_rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   exp_t sb[$];
   int acc_log[$];
   bit ok0a, ok0b, ok1a, ok1b, ok;
   int n, c;
   logic [7:0] d;
   int stray;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .clear(clear),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_addr(ram_addr), .ram_r_w(ram_r_w), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy));

   ram_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_lat3 (
      .clk(clk), .clear(b_clear),
      .req0_valid(b_valid), .req0_we(b_we), .req0_addr(b_addr), .req0_wdata(b_wdata),
      .req0_ready(b_ready), .rsp0_valid(b_rsp_valid), .rsp0_rdata(b_rsp_rdata),
      .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(1'b0), .req1_wdata(8'h00),
      .req1_ready(b1_ready), .rsp1_valid(b1_rsp_valid), .rsp1_rdata(b1_rsp_rdata),
      .ram_addr(b_ram_addr), .ram_r_w(b_ram_r_w), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
      .busy(b_busy));

   // RAM models: read data appears RD_LAT cycles after the ACCESS cycle
   logic [7:0] mem [2];
   logic [7:0] rpipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_r_w) mem[ram_addr] <= ram_wdata;
      rpipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[RD_LAT-1];

   logic [7:0] mem3 [2];
   logic [7:0] pipe3 [3];
   always @(posedge clk) begin
      if (b_ram_r_w) mem3[b_ram_addr] <= b_ram_wdata;
      pipe3[0] <= mem3[b_ram_addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign b_ram_rdata = pipe3[2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: every response pulse pops and is compared against the scoreboard
   always @(negedge clk) begin
      if (!clear) begin
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin
               if (sb.size() == 0) begin
                  check("rsp_unexpected", 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("rsp_port", p, e.port);
                  check("rsp_data", (p == 0) ? rsp0_rdata : rsp1_rdata, e.data);
                  check("rsp_cycle", cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic issue(input int port, input bit we, input logic [AW-1:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input bit push,
                        input int budget, output bit acc);
      exp_t e;
      acc = 1'b0;
      if (port == 0) begin
         req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd;
      end else begin
         req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd;
      end
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         if ((port == 0) ? req0_ready : req1_ready) begin
            @(posedge clk);
            #1;
            acc = 1'b1;
            acc_log.push_back(port);
            if (push) begin
               e.port = port;
               e.data = we ? 8'h00 : exp_rd;
               e.cyc  = cyc + 1 + (we ? 0 : RD_LAT);
               sb.push_back(e);
            end
         end
      end
      if (port == 0) req0_valid = 1'b0;
      else           req1_valid = 1'b0;
   endtask

   task automatic drain();
      bit idle = 1'b0;
      for (int i = 0; i < 60 && !idle; i++) begin
         @(posedge clk);
         #1;
         if (!busy && sb.size() == 0) idle = 1'b1;
      end
      check("drain_idle", idle, 1);
   endtask

   task automatic issue3(input bit we, input logic [AW-1:0] a, input logic [7:0] wd, output int nacc);
      b_valid = 1'b1; b_we = we; b_addr = a; b_wdata = wd;
      nacc = -1;
      for (int i = 0; i < 20 && nacc < 0; i++) begin
         @(negedge clk);
         if (b_ready) begin
            @(posedge clk);
            #1;
            nacc = cyc;
         end
      end
      b_valid = 1'b0;
      check("lat3_accept", (nacc >= 0) ? 1 : 0, 1);
   endtask

   task automatic wait_rsp3(output int cr, output logic [7:0] dr);
      cr = -1;
      dr = 8'h00;
      for (int i = 0; i < 20 && cr < 0; i++) begin
         @(negedge clk);
         if (b_rsp_valid) begin
            cr = cyc;
            dr = b_rsp_rdata;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b1; b_clear = 1'b1;
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
      b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_r_w", ram_r_w, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp0_rdata", rsp0_rdata, 0);
      check("rst_rsp1_rdata", rsp1_rdata, 0);
      check("rst_busy", busy, 0);
      clear = 1'b0; b_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_ready0", req0_ready, 0);
      check("idle_r_w", ram_r_w, 0);

      // 2: req0 write then read of address 0
      issue(0, 1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 10, ok);
      check("t2_wr_accept", ok, 1);
      check("t2_access_r_w", ram_r_w, 1);
      check("t2_access_addr", ram_addr, 0);
      check("t2_access_wdata", ram_wdata, 8'hAA);
      check("t2_access_busy", busy, 1);
      check("t2_access_ready0", req0_ready, 0);
      @(posedge clk);
      #1;
      check("t2_resp_r_w", ram_r_w, 0);
      issue(0, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b1, 10, ok);
      check("t2_rd_accept", ok, 1);
      drain();

      // 3: req1 write then read of address 1; rsp0 must not pulse and keeps its data
      issue(1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 10, ok);
      check("t3_access_addr", ram_addr, 1);
      check("t3_access_wdata", ram_wdata, 8'h55);
      issue(1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 10, ok);
      drain();
      check("t3_rsp0_hold", rsp0_rdata, 8'hAA);
      // single valid against the pointer: granted in the first IDLE cycle
      issue(1, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1, ok);
      check("t3_single_grant", ok, 1);
      drain();

      // 4: both requesters valid continuously
      acc_log.delete();
      fork
         begin
            issue(0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 40, ok0a);
            issue(0, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 40, ok0b);
         end
         begin
            issue(1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b1, 40, ok1a);
            issue(1, 1'b1, 1'b1, 8'h44, 8'h00, 1'b1, 40, ok1b);
         end
      join
      drain();
      check("t4_accept_cnt", acc_log.size(), 4);
      if (acc_log.size() == 4) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         check("t4_grant0", acc_log[0], 0);
         check("t4_grant1", acc_log[1], 1);
         check("t4_grant2", acc_log[2], 0);
         check("t4_grant3", acc_log[3], 1);
`else
         check("t4_grant0", acc_log[0], 0);
         check("t4_grant1", acc_log[1], 0);
         check("t4_grant2", acc_log[2], 1);
         check("t4_grant3", acc_log[3], 1);
`endif
      end

      // 5: clear in the cycle after ACCESS of a read aborts it without a response
      issue(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 10, ok);
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_no_rsp", rsp0_valid, 0);
      check("t5_rdata0_clr", rsp0_rdata, 0);
      check("t5_rdata1_clr", rsp1_rdata, 0);
      issue(0, 1'b0, 1'b1, 8'h00, 8'h44, 1'b1, 10, ok);
      issue(1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 10, ok);
      drain();

      // 6: RD_LAT=3 instance
      issue3(1'b1, 1'b1, 8'h5A, n);
      wait_rsp3(c, d);
      check("lat3_wr_cycle", c, n + 1);
      check("lat3_wr_data", d, 0);
      issue3(1'b0, 1'b1, 8'h00, n);
      @(posedge clk);
      #1;
      check("lat3_wait_r_w", b_ram_r_w, 0);
      check("lat3_wait_addr", b_ram_addr, 1);
      check("lat3_wait_busy", b_busy, 1);
      wait_rsp3(c, d);
      check("lat3_rd_cycle", c, n + 4);
      check("lat3_rd_data", d, 8'h5A);
      issue3(1'b0, 1'b1, 8'h00, n);
      @(posedge clk);
      #1;
      b_clear = 1'b1;
      @(posedge clk);
      #1;
      b_clear = 1'b0;
      check("lat3_clr_busy", b_busy, 0);
      stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (b_rsp_valid) stray++;
      end
      check("lat3_clr_no_rsp", stray, 0);
      issue3(1'b0, 1'b1, 8'h00, n);
      wait_rsp3(c, d);
      check("lat3_rd2_cycle", c, n + 4);
      check("lat3_rd2_data", d, 8'h5A);

      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
